// File: rtl/id_issue_queue.sv
// id_issue_queue: in-order circular buffer between the decoders and the issue stage.
// Takes up to NR_LANES decoded entries per cycle. Presents the NR_LANES oldest entries.
// Supports flush and decode stall. There is no enqueue-to-dequeue bypass.
module id_issue_queue #(
  parameter int NR_LANES = 2,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         stall_i,
  input  logic [NR_LANES-1:0]          enq_valid_i,
  input  logic [NR_LANES*DATA_W-1:0]   enq_data_i,
  output logic [NR_LANES-1:0]          enq_ready_o,
  output logic [NR_LANES-1:0]          deq_valid_o,
  output logic [NR_LANES*DATA_W-1:0]   deq_data_o,
  input  logic [NR_LANES-1:0]          deq_ack_i,
  output logic [$clog2(DEPTH):0]       count_o
);

  // A single-slot queue still needs a 1-bit pointer; the index mask keeps it at slot 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] IDX_MASK = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [NR_LANES-1:0] ack_eff;
  logic [CW-1:0]     n_deq;
  logic [CW-1:0]     n_enq;
  logic [CW-1:0]     free;

  assign count_o = count;

  // Issue-side view: lane k shows the k-th oldest entry straight from storage.
  genvar gi;
  generate
    for (gi = 0; gi < NR_LANES; gi++) begin : g_deq
      logic [PW-1:0] rd_idx;
      assign rd_idx = (rd_ptr + PW'(gi)) & IDX_MASK;
      assign deq_valid_o[gi] = (count > CW'(gi));
      assign deq_data_o[gi*DATA_W +: DATA_W] = mem[rd_idx];
    end
  endgenerate

  // Acks count only up to the first gap, and they are ignored during a flush.
  assign ack_eff = deq_ack_i & deq_valid_o & {NR_LANES{~flush_i}};

  // Count the leading acks and work out the space available after this cycle's pops.
  always_comb begin
    logic run;
    n_deq = '0;
    run   = 1'b1;
    for (int k = 0; k < NR_LANES; k++) begin
      run = run & ack_eff[k];
      if (run) n_deq = n_deq + CW'(1);
    end
    free = CW'(DEPTH) - count + n_deq;
  end

  // Accept a contiguous prefix of valid lanes that fits in the free space.
  always_comb begin
    logic pre;
    enq_ready_o = '0;
    n_enq       = '0;
    pre         = ~flush_i & ~stall_i & ~rst_i;
    for (int k = 0; k < NR_LANES; k++) begin
      pre = pre & enq_valid_i[k];
      enq_ready_o[k] = pre && (CW'(k) < free);
      if (enq_ready_o[k]) n_enq = n_enq + CW'(1);
    end
  end

  // Pointer and occupancy update. A flush empties the queue by moving the read pointer to the write pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(n_deq);
      wr_ptr <= wr_ptr + PW'(n_enq);
      count  <= count + n_enq - n_deq;
    end
  end

  // Entry storage. Accepted lane k lands k slots past the write pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else begin
      for (int k = 0; k < NR_LANES; k++) begin
        if (enq_ready_o[k]) begin
          mem[(wr_ptr + PW'(k)) & IDX_MASK] <= enq_data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
